// File: rtl/irq_controller.sv
// irq_controller: edge-latched, fixed-priority interrupt controller.
// Sits beside the control unit and decodes the same opcode bus. An accepted
// interrupt produces one call cycle (irq_take), then stays in service until RETI.
// Optional feature macro: IRQ_SYNC_EN adds a 2-flop input synchronizer
// (+2 cycles of latency) for peripheral lines that are asynchronous to clk.
module irq_controller #(
  parameter int              N_IRQ      = 4,
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int              VEC_STRIDE = 4,
  parameter logic [5:0]      OP_RETI    = 6'b111100,
  parameter logic [5:0]      OP_EI      = 6'b111101,
  parameter logic [5:0]      OP_DI      = 6'b111110,
  parameter logic [5:0]      OP_MSK     = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic [5:0]       opcode,
  input  logic [7:0]       imm,
  output logic             irq_take,
  output logic [PC_W-1:0]  irq_vector,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;

  state_t            state, state_nxt;
  logic [N_IRQ-1:0]  irq_s, irq_q, rise;
  logic [N_IRQ-1:0]  mask, eligible;
  logic              gie;
  logic              found;
  logic [IW-1:0]     gnt_idx;
  logic [N_IRQ-1:0]  gnt_oh;
  logic [PC_W-1:0]   gnt_vec;
  logic              take_go;
  logic              dec_en, is_ei, is_di, is_msk;
  logic              unused_imm;

  // imm bits above N_IRQ carry no meaning for the mask
  assign unused_imm = ^imm;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1, sync2;

  // Two-flop synchronizer for asynchronous peripheral lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq;
`endif

  // Previous-cycle copy of the request lines for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= '0;
    else        irq_q <= irq_s;
  end

  assign rise     = irq_s & ~irq_q;
  assign eligible = pending & mask;

  // Fixed priority: lowest set index of eligible wins
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (eligible[i] && !found) begin
        found   = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end

  assign gnt_oh  = found ? (N_IRQ'(1) << gnt_idx) : '0;
  assign gnt_vec = VEC_BASE + PC_W'(gnt_idx) * PC_W'(VEC_STRIDE);

  // The TAKE-cycle instruction is aborted, so its opcode is not decoded
  assign dec_en = (state != TAKE);
  assign is_ei  = dec_en && (opcode == OP_EI);
  assign is_di  = dec_en && (opcode == OP_DI);
  assign is_msk = dec_en && (opcode == OP_MSK);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a DI in the deciding cycle vetoes the take
  always_comb begin
    state_nxt = state;
    take_go   = 1'b0;
    case (state)
      IDLE: begin
        if (gie && found && (opcode != OP_DI)) begin
          take_go   = 1'b1;
          state_nxt = TAKE;
        end
      end
      TAKE:    state_nxt = SERVICE;
      SERVICE: if (opcode == OP_RETI) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; ack/vector hold the grant latched at the take decision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_take   <= 1'b0;
      irq_vector <= '0;
      irq_ack    <= '0;
      in_service <= 1'b0;
    end else begin
      irq_take   <= take_go;
      irq_vector <= take_go ? gnt_vec : '0;
      irq_ack    <= take_go ? gnt_oh : '0;
      in_service <= (state_nxt != IDLE);
    end
  end

  // Pending latch: granted line clears as TAKE begins; a new edge wins over the clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~(take_go ? gnt_oh : '0)) | rise;
  end

  // Global enable and mask, written by EI/DI/MSK in any non-TAKE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gie  <= 1'b0;
      mask <= '1;
    end else begin
      if (is_ei)      gie <= 1'b1;
      else if (is_di) gie <= 1'b0;
      if (is_msk) mask <= imm[N_IRQ-1:0];
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller (default build, no input synchronizer).
module tb_irq_controller;

  localparam logic [5:0] NOP  = 6'b000000;
  localparam logic [5:0] RETI = 6'b111100;
  localparam logic [5:0] EI   = 6'b111101;
  localparam logic [5:0] DI   = 6'b111110;
  localparam logic [5:0] MSK  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic [5:0] opcode;
  logic [7:0] imm;
  logic       irq_take;
  logic [9:0] irq_vector;
  logic [3:0] irq_ack;
  logic       in_service;
  logic [3:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  irq_controller dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .opcode    (opcode),
    .imm       (imm),
    .irq_take  (irq_take),
    .irq_vector(irq_vector),
    .irq_ack   (irq_ack),
    .in_service(in_service),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_take(input string tag, input logic [9:0] vec, input logic [3:0] ack,
                          input logic [3:0] pend);
    chk({tag, ".take"}, 32'(irq_take), 32'd1);
    chk({tag, ".vec"},  32'(irq_vector), 32'(vec));
    chk({tag, ".ack"},  32'(irq_ack), 32'(ack));
    chk({tag, ".insv"}, 32'(in_service), 32'd1);
    chk({tag, ".pend"}, 32'(pending), 32'(pend));
  endtask

  initial begin
    reset = 1'b0; irq = '0; opcode = NOP; imm = '0;
    #3;
    chk("rst.take", 32'(irq_take), 32'd0);
    chk("rst.vec",  32'(irq_vector), 32'd0);
    chk("rst.ack",  32'(irq_ack), 32'd0);
    chk("rst.insv", 32'(in_service), 32'd0);
    chk("rst.pend", 32'(pending), 32'd0);
    tick; tick;
    reset = 1'b1;

    // 1: EI, pulse irq[2], take two cycles after the edge
    opcode = EI;
    tick; opcode = NOP; irq = 4'b0100;
    tick; chk("t1.pend", 32'(pending), 32'h4); chk("t1.notake", 32'(irq_take), 32'd0);
    irq = '0;
    tick; chk_take("t1", 10'h3C8, 4'b0100, 4'b0000);
    tick; chk("t1.svc_take", 32'(irq_take), 32'd0); chk("t1.svc_ack", 32'(irq_ack), 32'd0);
    chk("t1.svc_insv", 32'(in_service), 32'd1);
    opcode = RETI;
    tick; chk("t1.reti_insv", 32'(in_service), 32'd0);
    opcode = NOP;

    // 2: lines 3 and 1 together, line 1 first, line 3 after RETI + one IDLE cycle
    irq = 4'b1010;
    tick; chk("t2.pend", 32'(pending), 32'hA); irq = '0;
    tick; chk_take("t2a", 10'h3C4, 4'b0010, 4'b1000);
    tick; chk("t2.svc_take", 32'(irq_take), 32'd0); chk("t2.svc_pend", 32'(pending), 32'h8);
    opcode = RETI;
    tick; chk("t2.idle_take", 32'(irq_take), 32'd0); chk("t2.idle_insv", 32'(in_service), 32'd0);
    opcode = NOP;
    tick; chk_take("t2b", 10'h3CC, 4'b1000, 4'b0000);

    // 3: edge during SERVICE stays pending, taken two cycles after RETI
    tick; irq = 4'b0001;
    tick; chk("t3.notake", 32'(irq_take), 32'd0); chk("t3.pend", 32'(pending), 32'h1);
    chk("t3.insv", 32'(in_service), 32'd1);
    irq = '0; opcode = RETI;
    tick; chk("t3.idle_insv", 32'(in_service), 32'd0); chk("t3.idle_take", 32'(irq_take), 32'd0);
    opcode = NOP;
    tick; chk_take("t3", 10'h3C0, 4'b0001, 4'b0000);
    tick; opcode = RETI;

    // 4: masked request stays pending until unmasked
    tick; opcode = MSK; imm = 8'h0E;
    tick; opcode = NOP; irq = 4'b0001;
    tick; chk("t4.pend", 32'(pending), 32'h1); irq = '0;
    tick; chk("t4.masked", 32'(irq_take), 32'd0); chk("t4.pend2", 32'(pending), 32'h1);
    opcode = MSK; imm = 8'h0F;
    tick; opcode = NOP; chk("t4.mskcyc", 32'(irq_take), 32'd0);
    tick; chk_take("t4", 10'h3C0, 4'b0001, 4'b0000);
    tick; opcode = RETI;

    // 5: DI in the deciding cycle suppresses the take; EI later lets it through
    tick; opcode = NOP; irq = 4'b0100;
    tick; chk("t5.pend", 32'(pending), 32'h4); irq = '0; opcode = DI;
    tick; opcode = NOP; chk("t5.di_take", 32'(irq_take), 32'd0); chk("t5.di_pend", 32'(pending), 32'h4);
    tick; chk("t5.off_take", 32'(irq_take), 32'd0);
    opcode = EI;
    tick; opcode = NOP; chk("t5.ei_take", 32'(irq_take), 32'd0);
    tick; chk_take("t5", 10'h3C8, 4'b0100, 4'b0000);

    // 6: reset during SERVICE with line 3 pending
    tick; irq = 4'b1000;
    tick; irq = '0;
    chk("t6.pend", 32'(pending), 32'h8); chk("t6.insv", 32'(in_service), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6.take", 32'(irq_take), 32'd0);
    chk("t6.vec",  32'(irq_vector), 32'd0);
    chk("t6.ack",  32'(irq_ack), 32'd0);
    chk("t6.insv0", 32'(in_service), 32'd0);
    chk("t6.pend0", 32'(pending), 32'd0);
    tick;
    reset = 1'b1; irq = 4'b1000;
    tick; chk("t6.rpend", 32'(pending), 32'h8); irq = '0;
    tick; chk("t6.gie0a", 32'(irq_take), 32'd0);
    tick; chk("t6.gie0b", 32'(irq_take), 32'd0); chk("t6.rpend2", 32'(pending), 32'h8);
    opcode = EI;
    tick; opcode = NOP;
    tick; chk_take("t6", 10'h3CC, 4'b1000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
